// File: rtl/jt12_eg_drv_if.sv
// Register-side bus for the EG driver: parameter write handshake and key commands.
interface jt12_eg_drv_if;
  logic       wr_en;
  logic       wr_ready;
  logic [4:0] wr_slot;
  logic [2:0] wr_field;
  logic [7:0] wr_data;
  logic       kon_we;
  logic [2:0] kon_ch;
  logic [3:0] kon_op;

  modport master (
    output wr_en, wr_slot, wr_field, wr_data, kon_we, kon_ch, kon_op,
    input  wr_ready
  );

  modport slave (
    input  wr_en, wr_slot, wr_field, wr_data, kon_we, kon_ch, kon_op,
    output wr_ready
  );
endinterface

// File: rtl/jt12_eg_drv.sv
// EG input driver: per-slot parameter store plus 24-slot rotation that presents
// each slot's fields at the stage-I, stage-II and stage-IV pipeline positions.
module jt12_eg_drv (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  jt12_eg_drv_if.slave     bus,
  output logic             zero,
  output logic [4:0]       arate_I,
  output logic [4:0]       rate1_I,
  output logic [4:0]       rate2_I,
  output logic [3:0]       rrate_I,
  output logic [3:0]       sl_I,
  output logic             ssg_en_I,
  output logic [2:0]       ssg_eg_I,
  output logic             keyon_I,
  output logic [4:0]       keycode_II,
  output logic [1:0]       ks_II,
  output logic [6:0]       tl_IV,
  output logic [1:0]       ams_IV,
  output logic             amsen_IV
);
  localparam int unsigned SLOTS  = 24;
  localparam int unsigned TL_RST = 127;
  localparam int unsigned RR_RST = 15;

  logic [4:0] arate_m   [SLOTS];
  logic [4:0] rate1_m   [SLOTS];
  logic [4:0] rate2_m   [SLOTS];
  logic [3:0] rrate_m   [SLOTS];
  logic [3:0] sl_m      [SLOTS];
  logic [6:0] tl_m      [SLOTS];
  logic [1:0] ks_m      [SLOTS];
  logic [1:0] ams_m     [SLOTS];
  logic       amsen_m   [SLOTS];
  logic       ssg_en_m  [SLOTS];
  logic [2:0] ssg_eg_m  [SLOTS];
  logic [4:0] keycode_m [SLOTS];
  logic [SLOTS-1:0] keyon_m;

  logic [4:0] scnt;
  logic       pend_v;
  logic [4:0] pend_slot;
  logic [2:0] pend_field;
  logic [7:0] pend_data;
  logic       kpend_v;
  logic [2:0] kpend_ch;
  logic [3:0] kpend_op;

  logic [4:0] scnt_n, s2, s4;
  logic       kon_ok;
  logic [2:0] kon_map;

  // The registered outputs move together with scnt, so they always describe slot scnt.
  always_comb begin
    scnt_n  = (scnt == 5'(SLOTS - 1)) ? 5'd0 : scnt + 5'd1;
    s2      = (scnt_n == 5'd0) ? 5'(SLOTS - 1) : scnt_n - 5'd1;
    s4      = (scnt_n < 5'd3) ? scnt_n + 5'(SLOTS - 3) : scnt_n - 5'd3;
    kon_ok  = (bus.kon_ch[1:0] != 2'b11);
    kon_map = bus.kon_ch[2] ? bus.kon_ch - 3'd1 : bus.kon_ch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        arate_m[i]   <= '0;
        rate1_m[i]   <= '0;
        rate2_m[i]   <= '0;
        rrate_m[i]   <= 4'(RR_RST);
        sl_m[i]      <= '0;
        tl_m[i]      <= 7'(TL_RST);
        ks_m[i]      <= '0;
        ams_m[i]     <= '0;
        amsen_m[i]   <= 1'b0;
        ssg_en_m[i]  <= 1'b0;
        ssg_eg_m[i]  <= '0;
        keycode_m[i] <= '0;
      end
      keyon_m      <= '0;
      scnt         <= '0;
      pend_v       <= 1'b0;
      pend_slot    <= '0;
      pend_field   <= '0;
      pend_data    <= '0;
      bus.wr_ready <= 1'b1;
      kpend_v      <= 1'b0;
      kpend_ch     <= '0;
      kpend_op     <= '0;
      zero         <= 1'b0;
      arate_I      <= '0;
      rate1_I      <= '0;
      rate2_I      <= '0;
      rrate_I      <= 4'(RR_RST);
      sl_I         <= '0;
      ssg_en_I     <= 1'b0;
      ssg_eg_I     <= '0;
      keyon_I      <= 1'b0;
      keycode_II   <= '0;
      ks_II        <= '0;
      tl_IV        <= 7'(TL_RST);
      ams_IV       <= '0;
      amsen_IV     <= 1'b0;
    end else begin
      if (bus.wr_en && bus.wr_ready) begin
        pend_v       <= 1'b1;
        pend_slot    <= bus.wr_slot;
        pend_field   <= bus.wr_field;
        pend_data    <= bus.wr_data;
        bus.wr_ready <= 1'b0;
      end

      if (clk_en) begin
        scnt       <= scnt_n;
        zero       <= (scnt_n == 5'd0);
        arate_I    <= arate_m[scnt_n];
        rate1_I    <= rate1_m[scnt_n];
        rate2_I    <= rate2_m[scnt_n];
        rrate_I    <= rrate_m[scnt_n];
        sl_I       <= sl_m[scnt_n];
        ssg_en_I   <= ssg_en_m[scnt_n];
        ssg_eg_I   <= ssg_eg_m[scnt_n];
        keyon_I    <= keyon_m[scnt_n];
        keycode_II <= keycode_m[s2];
        ks_II      <= ks_m[s2];
        tl_IV      <= tl_m[s4];
        ams_IV     <= ams_m[s4];
        amsen_IV   <= amsen_m[s4];

        // Commit lands after this edge's readout, so a same-slot read sees the old value.
        if (pend_v) begin
          pend_v       <= 1'b0;
          bus.wr_ready <= 1'b1;
          if (pend_slot < 5'(SLOTS)) begin
            case (pend_field)
              3'd0: arate_m[pend_slot] <= pend_data[4:0];
              3'd1: begin
                rate1_m[pend_slot] <= pend_data[4:0];
                amsen_m[pend_slot] <= pend_data[7];
              end
              3'd2: rate2_m[pend_slot] <= pend_data[4:0];
              3'd3: begin
                sl_m[pend_slot]    <= pend_data[7:4];
                rrate_m[pend_slot] <= pend_data[3:0];
              end
              3'd4: tl_m[pend_slot] <= pend_data[6:0];
              3'd5: begin
                ks_m[pend_slot]  <= pend_data[7:6];
                ams_m[pend_slot] <= pend_data[1:0];
              end
              3'd6: begin
                ssg_en_m[pend_slot] <= pend_data[3];
                ssg_eg_m[pend_slot] <= pend_data[2:0];
              end
              default: keycode_m[pend_slot] <= pend_data[4:0];
            endcase
          end
        end

        if (kpend_v) begin
          for (int op = 0; op < 4; op++)
            keyon_m[5'(op * 6 + 32'(kpend_ch))] <= kpend_op[op];
        end
      end

      // Latest key command wins until the next clk_en consumes it.
      if (bus.kon_we && kon_ok) begin
        kpend_v  <= 1'b1;
        kpend_ch <= kon_map;
        kpend_op <= bus.kon_op;
      end else if (clk_en) begin
        kpend_v <= 1'b0;
      end
    end
  end
endmodule
